// File: rtl/apb_master.sv
// APB requester: single command in, SETUP/ACCESS on the bus, single response out.
// Optional ACCESS wait-state timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state;

  // Gated with reset so no command is taken during the reset cycle.
  assign cmd_ready = (state == IDLE) && !PRESET;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;
`else
  logic unused_timeout_param;
  assign unused_timeout_param = (TIMEOUT_CYCLES < 1);
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            PADDR   <= cmd_addr;
            PWRITE  <= cmd_write;
            PWDATA  <= cmd_write ? cmd_wdata : '0;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            state   <= SETUP;
`ifdef APB_MASTER_TIMEOUT_EN
            to_cnt  <= '0;
`endif
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // PREADY is checked first so a completion in the limit cycle wins over the abort.
          if (PREADY) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= PSLVERR;
            rsp_rdata <= (!PWRITE && !PSLVERR) ? PRDATA : '0;
            state     <= RESP;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (to_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Randomized self-checking bench for apb_master against a word-memory reference model.
// Define APB_MASTER_TIMEOUT_EN for both files to exercise the timeout abort.
module tb_apb_master;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] PADDR;
  logic          PSEL, PENABLE, PWRITE;
  logic [DW-1:0] PWDATA, PRDATA;
  logic          PREADY, PSLVERR;

  always #5 PCLK = ~PCLK;

  apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  int total = 0;
  int bad   = 0;

  // refMem is the expected memory image; slaveMem is what the completer really holds.
  logic [31:0] refMem   [32];
  logic [31:0] slaveMem [32];

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic checkBus(input string tag, input logic sel, input logic en,
                          input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
    checkOutput({tag, "_psel"},    64'(PSEL),    64'(sel));
    checkOutput({tag, "_penable"}, 64'(PENABLE), 64'(en));
    checkOutput({tag, "_paddr"},   64'(PADDR),   64'(addr));
    checkOutput({tag, "_pwrite"},  64'(PWRITE),  64'(wr));
    checkOutput({tag, "_pwdata"},  64'(PWDATA),  64'(wdata));
  endtask

  task automatic randomJunk();
    cmd_valid = 1'($urandom);
    cmd_write = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
  endtask

  // Issues the command and walks through SETUP; ends just after the SETUP edge.
  task automatic startCommand(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    checkOutput("idle_cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge PCLK);
    @(negedge PCLK);
    randomJunk();
    checkBus("setup", 1'b1, 1'b0, addr, wr, wr ? wdata : 32'd0);
    checkOutput("setup_cmd_ready", 64'(cmd_ready), 64'd0);
    checkOutput("setup_rsp_valid", 64'(rsp_valid), 64'd0);
    PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
    @(posedge PCLK);
  endtask

  // Checks the response phase for rspDelay+1 cycles and returns to IDLE.
  task automatic finishResponse(input logic err, input logic [31:0] expData, input int rspDelay);
    for (int c = 0; c <= rspDelay; c++) begin
      @(negedge PCLK);
      PREADY = 1'b0; PSLVERR = 1'($urandom); PRDATA = $urandom;
      checkOutput("resp_valid",     64'(rsp_valid), 64'd1);
      checkOutput("resp_err",       64'(rsp_err),   64'(err));
      checkOutput("resp_rdata",     64'(rsp_rdata), 64'(expData));
      checkOutput("resp_psel",      64'(PSEL),      64'd0);
      checkOutput("resp_penable",   64'(PENABLE),   64'd0);
      checkOutput("resp_cmd_ready", 64'(cmd_ready), 64'd0);
      if (c == rspDelay) begin
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
      end else begin
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
      end
      @(posedge PCLK);
    end
    @(negedge PCLK);
    rsp_ready = 1'b0;
    checkOutput("done_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("done_cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("done_psel",      64'(PSEL),      64'd0);
  endtask

  // One complete transfer; starts and ends on a falling edge with the DUT idle.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input int waits, input logic err, input int rspDelay);
    logic [31:0] expData;
    logic [4:0]  idx;
    idx = addr[6:2];
    expData = (wr || err) ? 32'd0 : refMem[idx];
    if (wr && !err) refMem[idx] = wdata;
    startCommand(wr, addr, wdata);
    for (int i = 0; i <= waits; i++) begin
      @(negedge PCLK);
      randomJunk();
      checkBus("access", 1'b1, 1'b1, addr, wr, wr ? wdata : 32'd0);
      checkOutput("access_rsp_valid", 64'(rsp_valid), 64'd0);
      if (i == waits) begin
        PREADY  = 1'b1;
        PSLVERR = err;
        PRDATA  = PWRITE ? $urandom : slaveMem[PADDR[6:2]];
        if (PWRITE && !err) slaveMem[PADDR[6:2]] = PWDATA;
      end else begin
        PREADY = 1'b0; PSLVERR = 1'($urandom); PRDATA = $urandom;
      end
      @(posedge PCLK);
    end
    finishResponse(err, expData, rspDelay);
  endtask

  task automatic resetMidTransfer();
    startCommand(1'b1, 32'h0000_000C, 32'h1234_5678);
    repeat (2) begin
      @(negedge PCLK);
      PREADY = 1'b0; PSLVERR = 1'($urandom); PRDATA = $urandom;
      checkOutput("prereset_penable", 64'(PENABLE), 64'd1);
      @(posedge PCLK);
    end
    @(negedge PCLK);
    cmd_valid = 1'b0;
    PRESET = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    checkBus("midreset", 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("midreset_cmd_ready", 64'(cmd_ready), 64'd0);
    PRESET = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    checkOutput("postreset_cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("postreset_rsp_valid", 64'(rsp_valid), 64'd0);
  endtask

`ifdef APB_MASTER_TIMEOUT_EN
  task automatic timeoutTest();
    startCommand(1'b0, 32'h0000_0008, 32'd0);
    for (int i = 0; i < TO; i++) begin
      @(negedge PCLK);
      cmd_valid = 1'b0;
      PREADY = 1'b0; PSLVERR = 1'($urandom); PRDATA = $urandom;
      checkOutput("timeout_wait_penable", 64'(PENABLE), 64'd1);
      @(posedge PCLK);
    end
    finishResponse(1'b1, 32'd0, 1);
  endtask
`endif

  initial begin
    for (int i = 0; i < 32; i++) begin
      refMem[i]   = 32'd0;
      slaveMem[i] = 32'd0;
    end
    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    checkBus("reset", 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset_rsp_err",   64'(rsp_err),   64'd0);
    checkOutput("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
    checkOutput("reset_cmd_ready", 64'(cmd_ready), 64'd0);
    PRESET = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);

    applyStimulus(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 0, 1'b0, 0);
    applyStimulus(1'b0, 32'h0000_0004, 32'd0,         0, 1'b0, 0);
    applyStimulus(1'b0, 32'h0000_0004, 32'd0,         3, 1'b0, 0);
    applyStimulus(1'b0, 32'h0000_0040, 32'd0,         0, 1'b1, 0);
    applyStimulus(1'b1, 32'h0000_0040, 32'hCAFE_F00D, 1, 1'b0, 0);
    applyStimulus(1'b0, 32'h0000_0040, 32'd0,         0, 1'b0, 5);
    applyStimulus(1'b1, 32'h0000_0010, 32'h5555_AAAA, 2, 1'b1, 1);
    applyStimulus(1'b0, 32'h0000_0010, 32'd0,         0, 1'b0, 0);

    resetMidTransfer();
    applyStimulus(1'b0, 32'h0000_000C, 32'd0, 0, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      logic [4:0] idx;
      idx = 5'($urandom_range(0, 31));
      applyStimulus(1'($urandom), {25'd0, idx, 2'b00}, $urandom,
                    int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                    int'($urandom_range(0, 2)));
    end

`ifdef APB_MASTER_TIMEOUT_EN
    timeoutTest();
`else
    applyStimulus(1'b0, 32'h0000_0008, 32'd0, 120, 1'b0, 0);
`endif
    applyStimulus(1'b0, 32'h0000_0004, 32'd0, 0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester that drives the APB bus toward the team's APB completers, such as the RAM slave.
- Accepts single read/write commands on a valid/ready command port.
- Runs the standard SETUP -> ACCESS sequence on the bus.
- Returns read data and error status on a valid/ready response port.
- One transfer in flight at a time; no PPROT/PSTRB.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr and PADDR.
- DATA_WIDTH, 32, width of write/read data buses.
- TIMEOUT_CYCLES, 16, max wait-state cycles in ACCESS before abort (used only with the optional feature; must be >= 1).

Ports:
- PCLK  input  1  clock; all logic on rising edge.
- PRESET  input  1  reset, synchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_WIDTH  transfer address.
- cmd_wdata  input  DATA_WIDTH  write data.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer takes response.
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and errors-by-timeout.
- rsp_err  output  1  PSLVERR or timeout.
- PADDR  output  ADDR_WIDTH  APB address.
- PSEL  output  1  APB select.
- PENABLE  output  1  APB enable.
- PWRITE  output  1  APB direction.
- PWDATA  output  DATA_WIDTH  APB write data.
- PRDATA  input  DATA_WIDTH  APB read data.
- PREADY  input  1  APB ready.
- PSLVERR  input  1  APB error.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (PRESET=1 at a PCLK edge): state=IDLE; all outputs 0 (cmd_ready=0 during the reset cycle, 1 on the first cycle after); TO counter 0.
- All outputs are registered except cmd_ready, which is decoded from state (1 only in IDLE).
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1, PSEL=0, PENABLE=0.
  - On cmd_valid: latch cmd_addr -> PADDR and cmd_write -> PWRITE; latch cmd_wdata -> PWDATA if write, else PWDATA=0. Go to SETUP.
- SETUP: PSEL=1, PENABLE=0 for exactly one cycle; go to ACCESS unconditionally.
- ACCESS:
  - PSEL=1, PENABLE=1; hold PADDR, PWRITE and PWDATA stable.
  - PREADY=0: stay (wait state).
  - PREADY=1:
    - capture rsp_err=PSLVERR;
    - rsp_rdata = PRDATA for reads with PSLVERR=0, else 0;
    - drop PSEL/PENABLE next cycle; go to RESP with rsp_valid=1.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err stable until rsp_ready.
  - On rsp_ready: rsp_valid=0, go to IDLE.
  - New commands are not accepted until back in IDLE.
- PSLVERR and PRDATA are ignored whenever PREADY=0 or PENABLE=0.
- Latency: command accepted at edge N -> SETUP cycle N+1 -> ACCESS from N+2 -> with zero wait states, rsp_valid=1 from N+3. Minimum 4 cycles per transfer including the IDLE accept cycle.
- In IDLE and RESP, PADDR/PWRITE/PWDATA hold their last values.
- Reset mid-transfer (any state): bus returns to PSEL=0 and PENABLE=0 at that edge. Transfer is dropped; no response is produced.
- cmd_valid during non-IDLE states: ignored (cmd_ready=0); the command is not lost, the requester holds it.

Optional Feature:
- APB_MASTER_TIMEOUT_EN defined:
  - Counter increments each ACCESS cycle with PREADY=0; cleared on entering SETUP.
  - When the counter reaches TIMEOUT_CYCLES with PREADY still 0: abort on the next edge. PSEL=0, PENABLE=0, go to RESP with rsp_err=1, rsp_rdata=0.
  - If PREADY=1 in the same cycle the limit is hit, PREADY wins (normal completion).
- Not defined: no counter logic; ACCESS waits indefinitely; TIMEOUT_CYCLES unused.

Test Plan:
- Write addr 0x04 data 0xDEADBEEF, zero-wait completer -> PSEL rises cycle N+1, PENABLE at N+2, rsp_valid at N+3 with rsp_err=0, rsp_rdata=0. Read 0x04 -> rsp_rdata=0xDEADBEEF.
- Read with completer inserting 3 wait states -> PENABLE high 4 cycles; PADDR/PWRITE stable throughout; rsp_valid 1 cycle after PREADY.
- Completer returns PREADY=1, PSLVERR=1 on read of 0x40 -> rsp_err=1, rsp_rdata=0; next command proceeds normally.
- Hold rsp_ready=0 for 5 cycles after a read -> rsp_valid and data stable for all 5; cmd_ready=0 and PSEL=0 throughout; transfer completes on rsp_ready=1.
- Assert PRESET during ACCESS with PREADY=0 -> next cycle all outputs 0 and no rsp_valid; cmd_ready=1 on the first post-reset cycle.
- With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=4, PREADY stuck at 0 -> abort after 4 wait cycles, rsp_err=1, rsp_rdata=0. Without the macro -> PENABLE stays high for 100+ cycles.
